// File: rtl/dsc_mul_seq.sv
// Operand-issue / result-capture sequencer for the 3-input serial stochastic multiplier.
// Optional run timeout compiled in with `define DSC_MUL_SEQ_TIMEOUT_EN.
module dsc_mul_seq #(
    parameter int SNG_WIDTH      = 4,
    parameter int CLR_CYCLES     = 2,
    parameter int TIMEOUT_MARGIN = 16,
    localparam int Z_WIDTH       = 3 * SNG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SNG_WIDTH-1:0] in_a,
    input  logic [SNG_WIDTH-1:0] in_b,
    input  logic [SNG_WIDTH-1:0] in_c,
    output logic [SNG_WIDTH-1:0] mul_a,
    output logic [SNG_WIDTH-1:0] mul_b,
    output logic [SNG_WIDTH-1:0] mul_c,
    output logic                 mul_clr,
    output logic                 mul_en,
    input  logic                 mul_ov,
    input  logic [Z_WIDTH-1:0]   mul_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Z_WIDTH-1:0]   out_z,
    output logic                 busy,
    output logic                 err
);

    localparam int CLR_W = $clog2(CLR_CYCLES + 1);
    localparam int RUN_W = Z_WIDTH + 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        HOLD
    } state_t;

    state_t               state_reg, state_next;
    logic [CLR_W-1:0]     clr_cnt_reg;
    logic [RUN_W-1:0]     run_cnt_reg;
    logic                 mul_clr_reg, mul_en_reg, busy_reg, out_valid_reg;
    logic [Z_WIDTH-1:0]   out_z_reg;
    logic                 accept, timeout, timeout_hit;
    logic [SNG_WIDTH-1:0] op_in  [3];
    logic [SNG_WIDTH-1:0] op_reg [3];

`ifdef DSC_MUL_SEQ_TIMEOUT_EN
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'((1 << Z_WIDTH) + TIMEOUT_MARGIN - 1);
    logic err_reg;

    // Fires on the edge where the run counter would reach 2^Z_WIDTH + margin.
    assign timeout_hit = (run_cnt_reg == RUN_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else if (accept) begin
            err_reg <= 1'b0;
        end else if (timeout) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        timeout    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt_reg == CLR_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (mul_ov) begin
                    state_next = DRAIN;
                end else if (timeout_hit) begin
                    timeout    = 1'b1;
                    state_next = HOLD;
                end
            end
            DRAIN: state_next = HOLD;
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign op_in[0] = in_a;
    assign op_in[1] = in_b;
    assign op_in[2] = in_c;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_op
            always_ff @(posedge clk) begin
                if (!rst) begin
                    op_reg[gi] <= '0;
                end else if (accept) begin
                    op_reg[gi] <= op_in[gi];
                end
            end
        end
    endgenerate

    // Control outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            clr_cnt_reg   <= '0;
            run_cnt_reg   <= '0;
            mul_clr_reg   <= 1'b1;
            mul_en_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_z_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            mul_clr_reg   <= (state_next == CLEAR);
            mul_en_reg    <= (state_next == RUN);
            busy_reg      <= (state_next != IDLE);
            out_valid_reg <= (state_next == HOLD);
            if (accept) begin
                clr_cnt_reg <= '0;
                run_cnt_reg <= '0;
            end else if (state_reg == CLEAR) begin
                clr_cnt_reg <= clr_cnt_reg + CLR_W'(1);
            end else if (state_reg == RUN) begin
                run_cnt_reg <= run_cnt_reg + RUN_W'(1);
            end
            if (state_reg == DRAIN) begin
                out_z_reg <= mul_z;
            end else if (timeout) begin
                out_z_reg <= '1;
            end
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign mul_a     = op_reg[0];
    assign mul_b     = op_reg[1];
    assign mul_c     = op_reg[2];
    assign mul_clr   = mul_clr_reg;
    assign mul_en    = mul_en_reg;
    assign busy      = busy_reg;
    assign out_valid = out_valid_reg;
    assign out_z     = out_z_reg;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Self-checking bench for dsc_mul_seq: behavioural multiplier stand-in plus
// product/latency reference computed from operand arithmetic.
module tb_dsc_mul_seq;

    localparam int SW     = 4;
    localparam int ZW     = 3 * SW;
    localparam int CLR    = 2;
    localparam int PERIOD = 1 << ZW;
    localparam int MARGIN = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] in_a = '0, in_b = '0, in_c = '0;
    logic [SW-1:0] mul_a, mul_b, mul_c;
    logic          mul_clr, mul_en;
    logic          mul_ov = 1'b0;
    logic [ZW-1:0] mul_z = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [ZW-1:0] out_z;
    logic          busy, err;

    int n_checks = 0;
    int n_fail   = 0;

    bit ov_extra  = 1'b0;
    bit ov_enable = 1'b1;
    int en_cnt    = 0;

    dsc_mul_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .mul_clr(mul_clr), .mul_en(mul_en), .mul_ov(mul_ov), .mul_z(mul_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: overflow at enabled cycle PERIOD, exact product only
    // once the stream has finished and enable has dropped.
    always @(negedge clk) begin
        int prod;
        if (mul_clr) en_cnt = 0;
        else if (mul_en) en_cnt++;
        mul_ov = ov_extra || (ov_enable && mul_en && en_cnt == PERIOD);
        prod = int'(mul_a) * int'(mul_b) * int'(mul_c);
        mul_z = (en_cnt >= PERIOD && !mul_en) ? ZW'(prod) : ZW'(prod + 7);
    end

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul(input int a, input int b, input int c, input int hold,
                           input bit keep_valid, input bit ov_noise);
        int exp_z, lat, clr_n, en_n, bad, n;
        exp_z = (a * b * c) % PERIOD;
        in_a = SW'(a); in_b = SW'(b); in_c = SW'(c);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin tick(); n++; end
        chk("accept_wait", 32'(n), 0);
        tick();
        // decoy operands must never be sampled outside IDLE
        in_a = SW'(a + 3); in_b = SW'(b + 5); in_c = SW'(c + 9);
        in_valid = keep_valid;
        chk("in_ready_busy", 32'(in_ready), 0);
        chk("busy_run", 32'(busy), 1);
        chk("err_after_accept", 32'(err), 0);
        lat = 0; clr_n = 0; en_n = 0; bad = 0;
        while (!out_valid && lat < 6000) begin
            if (mul_clr) clr_n++;
            if (mul_en) en_n++;
            if (mul_a != SW'(a) || mul_b != SW'(b) || mul_c != SW'(c) || in_ready) bad++;
            ov_extra = ov_noise && (lat == 0);
            tick();
            lat++;
        end
        ov_extra = 1'b0;
        chk("latency", 32'(lat), CLR + PERIOD + 1);
        chk("clr_cycles", 32'(clr_n), CLR);
        chk("en_cycles", 32'(en_n), PERIOD);
        chk("operands_stable", 32'(bad), 0);
        chk("out_z", 32'(out_z), 32'(exp_z));
        bad = 0;
        if (hold > 0) out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            ov_extra = ov_noise && (i == 1);
            tick();
            if (out_z != ZW'(exp_z) || !out_valid || in_ready || mul_a != SW'(a)) bad++;
        end
        ov_extra = 1'b0;
        chk("hold_stable", 32'(bad), 0);
        out_ready = 1'b1;
        tick();
        chk("out_valid_cleared", 32'(out_valid), 0);
        chk("in_ready_idle", 32'(in_ready), 1);
        chk("busy_idle", 32'(busy), 0);
        chk("out_z_kept", 32'(out_z), 32'(exp_z));
        in_valid = 1'b0;
        $display("mul a=%0d b=%0d c=%0d -> out_z=%0d latency=%0d hold=%0d", a, b, c, out_z, lat, hold);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_mul_clr", 32'(mul_clr), 1);
        chk("rst_mul_en", 32'(mul_en), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_out_z", 32'(out_z), 0);
        rst = 1'b1;
        tick();
        chk("idle_mul_clr", 32'(mul_clr), 0);

        // reset in the middle of a run
        in_a = 4'd5; in_b = 4'd6; in_c = 4'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!mul_en && n < 20) begin tick(); n++; end
        chk("reach_run", 32'(mul_en), 1);
        repeat (99) tick();
        rst = 1'b0;
        tick();
        chk("midrst_mul_clr", 32'(mul_clr), 1);
        chk("midrst_mul_en", 32'(mul_en), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_mul_a", 32'(mul_a), 0);
        rst = 1'b1;
        tick();
        chk("midrst_in_ready", 32'(in_ready), 1);
        $display("reset mid-run: mul_clr=%0d busy=%0d in_ready=%0d", mul_clr, busy, in_ready);

        run_mul(15, 15, 15, 2, 1'b0, 1'b0);
        run_mul(8, 8, 8, 50, 1'b1, 1'b0);
        run_mul(3, 5, 7, 0, 1'b0, 1'b0);
        run_mul(0, 9, 5, 4, 1'b0, 1'b1);
        run_mul(1, 1, 1, 0, 1'b0, 1'b0);
        run_mul(15, 15, 1, 0, 1'b0, 1'b0);
        for (int t = 0; t < 3; t++) begin
            run_mul(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 5)), 1'b0, 1'b0);
        end

`ifdef DSC_MUL_SEQ_TIMEOUT_EN
        begin
            int lat, en_n;
            ov_enable = 1'b0;
            in_a = 4'd7; in_b = 4'd7; in_c = 4'd7; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 0; en_n = 0;
            while (!out_valid && lat < 6000) begin
                if (mul_en) en_n++;
                tick();
                lat++;
            end
            chk("to_latency", 32'(lat), CLR + PERIOD + MARGIN);
            chk("to_en_cycles", 32'(en_n), PERIOD + MARGIN);
            chk("to_out_z", 32'(out_z), PERIOD - 1);
            chk("to_err", 32'(err), 1);
            chk("to_mul_en", 32'(mul_en), 0);
            tick();
            chk("to_err_idle", 32'(err), 1);
            $display("timeout: out_z=%0d err=%0d latency=%0d", out_z, err, lat);
            ov_enable = 1'b1;
            run_mul(2, 3, 4, 1, 1'b0, 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
